// File: rtl/bpu_btb_bht_if.sv
// Fetch-query and branch-resolution bundle for the branch prediction unit.
// The fetch/resolve side drives through 'master'; the predictor sits on 'slave'.
interface bpu_btb_bht_if #(
  parameter int ADDR_W = 32,
  parameter int GHR_W  = 1
);
  logic              rdy;
  logic [ADDR_W-1:0] addr;
  logic              fetch_en;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic [GHR_W-1:0]  pred_ghr;
  logic              busy;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_addr;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_mispred;
  logic [GHR_W-1:0]  upd_ghr;

  modport master (
    output rdy, addr, fetch_en,
    output upd_valid, upd_addr, upd_taken, upd_target, upd_mispred, upd_ghr,
    input  pred_hit, pred_taken, pred_target, pred_ghr, busy
  );

  modport slave (
    input  rdy, addr, fetch_en,
    input  upd_valid, upd_addr, upd_taken, upd_target, upd_mispred, upd_ghr,
    output pred_hit, pred_taken, pred_target, pred_ghr, busy
  );
endinterface

// File: rtl/bpu_btb_bht.sv
// Branch prediction unit: direct-mapped BTB plus a table of saturating
// direction counters, optionally gshare-indexed from a speculative global
// history. Tables are cleared by a sweep after reset; queries are
// combinational, training lands one cycle after the resolving edge.
module bpu_btb_bht #(
  parameter int ADDR_W   = 32,
  parameter int IDX_W    = 7,
  parameter int TAG_W    = 5,
  parameter int TGT_W    = 13,
  parameter int CNT_W    = 2,
  parameter int CNT_INIT = 2,
  parameter int HIST_LEN = 0
) (
  input  logic          clk,
  input  logic          rst,
  bpu_btb_bht_if.slave  bus
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int GHR_W   = (HIST_LEN > 0) ? HIST_LEN : 1;

  typedef enum logic [0:0] {
    SWEEP = 1'b0,
    READY = 1'b1
  } state_e;

  // History zero-extended to table index width; bimodal mode ignores it.
  function automatic logic [IDX_W-1:0] hist_ext(input logic [GHR_W-1:0] h);
    logic [IDX_W-1:0] r;
    if (HIST_LEN > 0) begin
      r = IDX_W'(h);
    end else begin
      r = {IDX_W{1'b0}};
    end
    return r;
  endfunction

  // One saturating step of a direction counter.
  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c, input logic up);
    logic [CNT_W-1:0] r;
    r = c;
    if (up) begin
      if (c != {CNT_W{1'b1}}) begin
        r = c + CNT_W'(1);
      end else begin
        r = c;
      end
    end else begin
      if (c != {CNT_W{1'b0}}) begin
        r = c - CNT_W'(1);
      end else begin
        r = c;
      end
    end
    return r;
  endfunction

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   sweep_ptr_q, sweep_ptr_d;
  logic [GHR_W-1:0]   ghr_q, ghr_d;

  // Tables are not reset: the sweep clears valid bits and counters, and
  // queries are masked while it runs.
  logic               btb_v_q   [ENTRIES];
  logic [TAG_W-1:0]   btb_tag_q [ENTRIES];
  logic [TGT_W-1:0]   btb_tgt_q [ENTRIES];
  logic [CNT_W-1:0]   cnt_q     [ENTRIES];

  logic               busy_s;
  logic               sweep_we_s;
  logic               upd_fire_s;
  logic [IDX_W-1:0]   q_idx_s, q_bidx_s;
  logic [TAG_W-1:0]   q_tag_s;
  logic [IDX_W-1:0]   u_idx_s, u_bidx_s;
  logic [TAG_W-1:0]   u_tag_s;
  logic [CNT_W-1:0]   cnt_new_s;
  logic [GHR_W:0]     repair_hist_s;
  logic [GHR_W:0]     spec_hist_s;
  logic               unused_bits;

  assign busy_s = (state_q == SWEEP);

  // Query and update index/tag extraction; update path uses the carried snapshot.
  always_comb begin
    q_idx_s  = bus.addr[IDX_W+1:2];
    q_tag_s  = bus.addr[IDX_W+TAG_W+1:IDX_W+2];
    q_bidx_s = q_idx_s ^ hist_ext(ghr_q);
    u_idx_s  = bus.upd_addr[IDX_W+1:2];
    u_tag_s  = bus.upd_addr[IDX_W+TAG_W+1:IDX_W+2];
    u_bidx_s = u_idx_s ^ hist_ext(bus.upd_ghr);
  end

  // Same-cycle prediction from current table contents (no write bypass).
  always_comb begin
    bus.pred_hit    = !busy_s && btb_v_q[q_idx_s] && (btb_tag_q[q_idx_s] == q_tag_s);
    bus.pred_taken  = bus.pred_hit && cnt_q[q_bidx_s][CNT_W-1];
    bus.pred_target = {bus.addr[ADDR_W-1:TGT_W], btb_tgt_q[q_idx_s]};
    if (HIST_LEN > 0) begin
      bus.pred_ghr = ghr_q;
    end else begin
      bus.pred_ghr = {GHR_W{1'b0}};
    end
    bus.busy = busy_s;
  end

  assign upd_fire_s = bus.rdy && !busy_s && bus.upd_valid;
  assign cnt_new_s  = sat_step(cnt_q[u_bidx_s], bus.upd_taken);

  // Sweep FSM: one entry cleared per enabled cycle, then READY until reset.
  always_comb begin
    state_d     = state_q;
    sweep_ptr_d = sweep_ptr_q;
    sweep_we_s  = 1'b0;
    case (state_q)
      SWEEP: begin
        if (bus.rdy) begin
          sweep_we_s  = 1'b1;
          sweep_ptr_d = sweep_ptr_q + IDX_W'(1);
          if (sweep_ptr_q == {IDX_W{1'b1}}) begin
            state_d = READY;
          end else begin
            state_d = SWEEP;
          end
        end else begin
          state_d = SWEEP;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d     = SWEEP;
        sweep_ptr_d = {IDX_W{1'b0}};
      end
    endcase
  end

  // Global history: mispredict repair wins over the speculative fetch shift.
  always_comb begin
    ghr_d         = ghr_q;
    repair_hist_s = {bus.upd_ghr, bus.upd_taken};
    spec_hist_s   = {ghr_q, bus.pred_taken};
    if (HIST_LEN == 0) begin
      ghr_d = {GHR_W{1'b0}};
    end else if (bus.rdy && !busy_s && bus.upd_valid && bus.upd_mispred) begin
      ghr_d = repair_hist_s[GHR_W-1:0];
    end else if (bus.rdy && !busy_s && bus.fetch_en) begin
      ghr_d = spec_hist_s[GHR_W-1:0];
    end else begin
      ghr_d = ghr_q;
    end
  end

  // Control state with asynchronous reset back to the start of the sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SWEEP;
      sweep_ptr_q <= {IDX_W{1'b0}};
      ghr_q       <= {GHR_W{1'b0}};
    end else begin
      state_q     <= state_d;
      sweep_ptr_q <= sweep_ptr_d;
      ghr_q       <= ghr_d;
    end
  end

  // Table writes: sweep clears, resolved branches train (taken ones allocate).
  always_ff @(posedge clk) begin
    if (sweep_we_s) begin
      btb_v_q[sweep_ptr_q] <= 1'b0;
      cnt_q[sweep_ptr_q]   <= CNT_W'(CNT_INIT);
    end else if (upd_fire_s) begin
      cnt_q[u_bidx_s] <= cnt_new_s;
      if (bus.upd_taken) begin
        btb_v_q[u_idx_s]   <= 1'b1;
        btb_tag_q[u_idx_s] <= u_tag_s;
        btb_tgt_q[u_idx_s] <= bus.upd_target[TGT_W-1:0];
      end
    end
  end

  // Address bits outside index/tag/target fields are intentionally ignored.
  assign unused_bits = ^{bus.addr, bus.upd_addr, bus.upd_target};

endmodule

// File: tb/tb_bpu_btb_bht.sv
// Self-checking bench: one bimodal and one gshare (HIST_LEN=4) instance
// against an abstract table model, plus hand-computed directed checks.
module tb_bpu_btb_bht;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bpu_btb_bht_if #(.ADDR_W(32), .GHR_W(1)) if0 ();
  bpu_btb_bht_if #(.ADDR_W(32), .GHR_W(4)) if1 ();

  bpu_btb_bht #(.HIST_LEN(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  bpu_btb_bht #(.HIST_LEN(4)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- abstract model ----------------
  int m_busy [2];
  int m_ghr  [2];
  bit m_v    [2][128];
  int m_tag  [2][128];
  int m_tgt  [2][128];
  int m_cnt  [2][128];
  int hlen   [2] = '{0, 4};

  task automatic model_cycle(input int m, input logic rdy, input logic [31:0] addr,
                             input logic fe, input logic uv, input logic [31:0] ua,
                             input logic ut, input logic [31:0] utg, input logic um,
                             input logic [3:0] ug, input logic hit, input logic tk,
                             input logic [31:0] tgt, input logic [3:0] ghr_o,
                             input logic busy_o);
    int idx, tag, bidx, uidx, ubidx, mask;
    bit e_hit, e_tk;
    mask = (1 << hlen[m]) - 1;
    if (rst) begin
      m_busy[m] = 128;
      m_ghr[m]  = 0;
      chk($sformatf("d%0d_rst_busy", m), busy_o, 1);
      chk($sformatf("d%0d_rst_hit", m), hit, 0);
      chk($sformatf("d%0d_rst_taken", m), tk, 0);
      chk($sformatf("d%0d_rst_ghr", m), ghr_o, 0);
      return;
    end
    idx   = (addr >> 2) % 128;
    tag   = (addr >> 9) % 32;
    bidx  = idx ^ m_ghr[m];
    e_hit = (m_busy[m] == 0) && m_v[m][idx] && (m_tag[m][idx] == tag);
    e_tk  = e_hit && (m_cnt[m][bidx] >= 2);
    chk($sformatf("d%0d_busy", m), busy_o, (m_busy[m] > 0));
    chk($sformatf("d%0d_hit", m), hit, e_hit);
    chk($sformatf("d%0d_taken", m), tk, e_tk);
    chk($sformatf("d%0d_ghr", m), ghr_o, m_ghr[m]);
    if (e_hit) chk($sformatf("d%0d_target", m), tgt, (addr & 32'hFFFF_E000) | m_tgt[m][idx]);
    if (!rdy) return;
    if (m_busy[m] > 0) begin
      m_busy[m]--;
      if (m_busy[m] == 0) begin
        for (int i = 0; i < 128; i++) begin
          m_v[m][i]   = 1'b0;
          m_cnt[m][i] = 2;
        end
      end
      return;
    end
    if (uv) begin
      uidx  = (ua >> 2) % 128;
      ubidx = uidx ^ (ug & mask);
      if (ut) m_cnt[m][ubidx] = (m_cnt[m][ubidx] < 3) ? m_cnt[m][ubidx] + 1 : 3;
      else    m_cnt[m][ubidx] = (m_cnt[m][ubidx] > 0) ? m_cnt[m][ubidx] - 1 : 0;
      if (ut) begin
        m_v[m][uidx]   = 1'b1;
        m_tag[m][uidx] = (ua >> 9) % 32;
        m_tgt[m][uidx] = utg & 32'h1FFF;
      end
    end
    if (uv && um) m_ghr[m] = ((ug << 1) | ut) & mask;
    else if (fe)  m_ghr[m] = ((m_ghr[m] << 1) | e_tk) & mask;
  endtask

  // Compare process: every cycle, both instances, then advance the model.
  initial begin
    forever begin
      @(negedge clk);
      model_cycle(0, if0.rdy, if0.addr, if0.fetch_en, if0.upd_valid, if0.upd_addr,
                  if0.upd_taken, if0.upd_target, if0.upd_mispred, {3'b000, if0.upd_ghr},
                  if0.pred_hit, if0.pred_taken, if0.pred_target, {3'b000, if0.pred_ghr},
                  if0.busy);
      model_cycle(1, if1.rdy, if1.addr, if1.fetch_en, if1.upd_valid, if1.upd_addr,
                  if1.upd_taken, if1.upd_target, if1.upd_mispred, if1.upd_ghr,
                  if1.pred_hit, if1.pred_taken, if1.pred_target, if1.pred_ghr,
                  if1.busy);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    if0.fetch_en = 1'b0; if0.upd_valid = 1'b0; if0.upd_mispred = 1'b0;
    if0.upd_taken = 1'b0; if0.upd_ghr = 1'b0;
    if1.fetch_en = 1'b0; if1.upd_valid = 1'b0; if1.upd_mispred = 1'b0;
    if1.upd_taken = 1'b0; if1.upd_ghr = 4'b0000;
  endtask

  // Count busy cycles after reset release; noise adds an rdy gap and ignored traffic.
  task automatic sweep_count(input bit noise, output int n);
    n = 0;
    for (int j = 0; j < 400; j++) begin
      if0.rdy = !(noise && j >= 40 && j < 50);
      if1.rdy = if0.rdy;
      if0.upd_valid = noise && j >= 60 && j < 63;
      if0.upd_addr = 32'h1040; if0.upd_taken = 1'b1; if0.upd_target = 32'h1200;
      if1.fetch_en = noise;
      if1.upd_valid = noise && j == 70;
      if1.upd_mispred = noise && j == 70;
      if1.upd_ghr = 4'b0101; if1.upd_taken = 1'b1; if1.upd_addr = 32'h1040;
      if1.upd_target = 32'h1200;
      @(negedge clk);
      if (!if0.busy) break;
      n++;
      step();
    end
    step();
    clr_in();
    if0.rdy = 1'b1;
    if1.rdy = 1'b1;
  endtask

  task automatic upd0(input logic [31:0] a, input logic t, input logic [31:0] tg);
    if0.upd_valid = 1'b1; if0.upd_addr = a; if0.upd_taken = t; if0.upd_target = tg;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst = 1'b1;
    if0.rdy = 1'b1; if1.rdy = 1'b1;
    if0.addr = 32'h0; if1.addr = 32'h0;
    if0.upd_addr = 32'h0; if0.upd_target = 32'h0;
    if1.upd_addr = 32'h0; if1.upd_target = 32'h0;
    clr_in();
    @(negedge clk);
    chk("reset_busy", if0.busy, 1'b1);
    chk("reset_ghr_gshare", if1.pred_ghr, 4'b0000);
    step();
    step();
    rst = 1'b0;

    // Sweep with a 10-cycle rdy gap and traffic that must be ignored.
    sweep_count(1'b1, n);
    chk("sweep_gap_len", n, 138);
    if0.addr = 32'h1040;
    @(negedge clk);
    chk("no_alloc_in_sweep", if0.pred_hit, 1'b0);
    chk("ghr_untouched_in_sweep", if1.pred_ghr, 4'b0000);
    step();

    // Train and hit.
    upd0(32'h1040, 1'b1, 32'h1200);
    if0.addr = 32'h100;
    step();
    clr_in();
    if0.addr = 32'h1040;
    @(negedge clk);
    chk("train_hit", if0.pred_hit, 1'b1);
    chk("train_taken", if0.pred_taken, 1'b1);
    chk("train_target", if0.pred_target, 32'h1200);
    step();

    // Counter down: 3 -> 1.
    upd0(32'h1040, 1'b0, 32'h0);
    step(); step();
    clr_in();
    @(negedge clk);
    chk("cnt1_hit", if0.pred_hit, 1'b1);
    chk("cnt1_nt", if0.pred_taken, 1'b0);
    step();
    // Saturate at 0, then one taken -> 1.
    upd0(32'h1040, 1'b0, 32'h0);
    step(); step();
    upd0(32'h1040, 1'b1, 32'h1200);
    step();
    clr_in();
    @(negedge clk);
    chk("sat_then_up_nt", if0.pred_taken, 1'b0);
    step();

    // Alias: same index, different tag.
    if0.addr = 32'h3040;
    @(negedge clk);
    chk("alias_miss", if0.pred_hit, 1'b0);
    step();

    // Same-cycle query and update: old data now, new data next cycle.
    if0.addr = 32'h1040;
    upd0(32'h1040, 1'b1, 32'h1200);
    @(negedge clk);
    chk("same_cycle_old", if0.pred_taken, 1'b0);
    step();
    clr_in();
    @(negedge clk);
    chk("same_cycle_new", if0.pred_taken, 1'b1);
    step();

    // Upper target bits come from the query address.
    if0.addr = 32'h0008_1040;
    @(negedge clk);
    chk("upper_hit", if0.pred_hit, 1'b1);
    chk("upper_target", if0.pred_target, 32'h0008_1200);
    step();

    // rdy low freezes training.
    if0.addr = 32'h1040;
    if0.rdy = 1'b0; if1.rdy = 1'b0;
    upd0(32'h1040, 1'b0, 32'h0);
    step(); step(); step();
    clr_in();
    if0.rdy = 1'b1; if1.rdy = 1'b1;
    @(negedge clk);
    chk("rdy_freeze", if0.pred_taken, 1'b1);
    step();

    // Reset mid-run restarts the sweep and clears everything.
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    sweep_count(1'b0, n);
    chk("sweep_len", n, 128);
    if0.addr = 32'h100;  @(negedge clk); chk("clr_100", if0.pred_hit, 1'b0);  step();
    if0.addr = 32'h1FC;  @(negedge clk); chk("clr_1fc", if0.pred_hit, 1'b0);  step();
    if0.addr = 32'h3000; @(negedge clk); chk("clr_3000", if0.pred_hit, 1'b0); step();
    if0.addr = 32'h1040; @(negedge clk); chk("clr_1040", if0.pred_hit, 1'b0); step();

    // gshare: build history 0110, then repair with upd_ghr=0001, taken.
    if1.upd_valid = 1'b1; if1.upd_addr = 32'h1040; if1.upd_taken = 1'b1;
    if1.upd_target = 32'h1200; if1.upd_ghr = 4'b0000;
    step();
    clr_in();
    if1.addr = 32'h1040; if1.fetch_en = 1'b1;
    @(negedge clk); chk("gs_fetch1_taken", if1.pred_taken, 1'b1); step();
    @(negedge clk); chk("gs_fetch2_taken", if1.pred_taken, 1'b1); step();
    if1.addr = 32'h2000;
    @(negedge clk); chk("gs_fetch3_nt", if1.pred_taken, 1'b0); step();
    if1.upd_valid = 1'b1; if1.upd_mispred = 1'b1; if1.upd_ghr = 4'b0001;
    if1.upd_taken = 1'b1; if1.upd_addr = 32'h1040; if1.upd_target = 32'h1200;
    @(negedge clk); chk("gs_ghr_0110", if1.pred_ghr, 4'b0110); step();
    clr_in();
    @(negedge clk); chk("gs_ghr_repair", if1.pred_ghr, 4'b0011); step();
    // Move history to 0001, then one not-taken at bidx 0x11 (3 -> 2 stays taken).
    if1.upd_valid = 1'b1; if1.upd_mispred = 1'b1; if1.upd_ghr = 4'b0000;
    if1.upd_taken = 1'b1; if1.upd_addr = 32'h2000; if1.upd_target = 32'h2400;
    step();
    clr_in();
    if1.upd_valid = 1'b1; if1.upd_ghr = 4'b0001; if1.upd_taken = 1'b0;
    if1.upd_addr = 32'h1040;
    step();
    clr_in();
    if1.addr = 32'h1040;
    @(negedge clk);
    chk("gs_ghr_0001", if1.pred_ghr, 4'b0001);
    chk("gs_repair_cnt_hit", if1.pred_hit, 1'b1);
    chk("gs_repair_cnt_taken", if1.pred_taken, 1'b1);
    step();

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
